bsg_manycore_barrier_edge_responder: RTL
========================================

Name: bsg_manycore_barrier_edge_responder

Overview:
Terminates the east-edge barrier links (local and ruche) of a compute-tile subarray and acts as one aggregate external barrier participant for all rows. It collects arrival toggles from every row and, optionally, from a host-side participant through a valid/ready handshake. After a programmable delay it releases the barrier by toggling its outputs back into the array. It sits between the array's east barrier edge and the host/IO side of the pod.

Parameters:
num_rows_p, 4, number of subarray rows terminated (one local link per row)
ruche_factor_p, 3, barrier ruche lanes per row
sync_latency_p, 2, extra cycles between full arrival and release (0 allowed)
cnt_width_p, 16, width of barrier-completion counter and timeout counter

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
barrier_link_i  in  num_rows_p  per-row local barrier link from array east edge
barrier_link_o  out  num_rows_p  per-row local barrier link into array east edge
barrier_ruche_link_i  in  num_rows_p*ruche_factor_p  ruche lanes from array, [row][lane]
barrier_ruche_link_o  out  num_rows_p*ruche_factor_p  ruche lanes into array
host_en_i  in  1  1 = host is a barrier participant
host_arrive_v_i  in  1  host arrival valid
host_arrive_ready_o  out  1  host arrival accepted when v&ready
host_release_v_o  out  1  one-cycle release pulse to host
barrier_count_o  out  cnt_width_p  completed barriers, wraps modulo 2^cnt_width_p
error_o  out  1  sticky protocol error
timeout_o  out  1  sticky timeout flag (see Optional Feature)

Behaviour:
- Clock is clk_i. Reset is synchronous, active-high, on reset_i.
- Link semantics: 1-bit phase. A row has arrived when barrier_link_i[r] != phase_r. Release = phase_r flips.
- Reset: phase_r=0, state=COLLECT, every output 0, host_arrived_r=0, counters 0, error_o=0, timeout_o=0. A reset mid-barrier discards all partial arrivals.
- barrier_link_o[r] = phase_r for all r. barrier_ruche_link_o[r][l] = phase_r for all r,l. Both are registered.
- COLLECT:
  - host_arrive_ready_o = host_en_i & ~host_arrived_r.
  - When host_arrive_v_i & host_arrive_ready_o, set host_arrived_r.
  - all_in = (every barrier_link_i[r] != phase_r) & (~host_en_i | host_arrived_r).
  - all_in with sync_latency_p==0 goes to RELEASE.
  - all_in with sync_latency_p>0 loads delay_cnt = sync_latency_p-1 and goes to DELAY.
- DELAY: host_arrive_ready_o=0. Decrement delay_cnt each cycle. At 0, go to RELEASE.
- RELEASE (single cycle):
  - phase_r <= ~phase_r, host_release_v_o=1 only if host_en_i, barrier_count_o += 1 (wraps), host_arrived_r <= 0.
  - Next state is COLLECT.
- Latency: all_in observed in cycle N, outputs toggle visible at N+1+sync_latency_p.
- host_release_v_o is high only in the RELEASE cycle.
- Partial arrivals are held indefinitely. Rows may arrive in any order or cycle.
- Retraction: in COLLECT or DELAY, a row seen arrived that returns to barrier_link_i==phase_r sets error_o. The row counts as not arrived and the barrier waits.
- Ruche consistency: barrier_ruche_link_i[r][l] != barrier_link_i[r] for 2 consecutive cycles sets error_o. Ruche inputs are otherwise ignored.
- host_en_i may change only in COLLECT with host_arrived_r=0. Any other change is unsupported and its behaviour is undefined.
- The host cannot arrive twice per barrier: ready stays low until the next COLLECT after release.

Optional Feature:
BSG_MANYCORE_BARRIER_RESP_TIMEOUT_EN:
- Defined:
  - A cnt_width_p timeout counter clears on RELEASE and on reset.
  - It increments each cycle in COLLECT while at least one participant has arrived and all_in=0.
  - When it reaches all-ones, timeout_o sets (sticky until reset) and the counter saturates.
  - Barrier operation is otherwise unaffected.
- Undefined: the counter is absent and timeout_o is tied to 0.

Test Plan:
- Reset, then num_rows_p=4, host_en_i=0, rows 0..3 toggle to 1 at cycles 5,9,3,12 -> barrier_link_o and all ruche_o become 1 at cycle 12+1+2=15; barrier_count_o=1; host_release_v_o stays 0.
- host_en_i=1, all rows arrive at cycle 4, host_arrive_v_i at cycle 20 -> handshake accepted at 20, release at 23, host_release_v_o=1 for exactly cycle 23, ready low during 21-23, high again at 24.
- sync_latency_p=0, back-to-back barriers (rows toggle 0->1, then 1->0 right after release) -> outputs toggle one cycle after each full arrival; count increments by 2.
- Row 2 arrives, then deasserts back to phase before others arrive -> error_o=1 sticky, no release until row 2 re-arrives.
- reset_i asserted during DELAY -> next cycle all outputs 0, count 0, no release pulse; a new barrier completes normally.
- With BSG_MANYCORE_BARRIER_RESP_TIMEOUT_EN and cnt_width_p=4: one row arrives, others idle -> timeout_o=1 after 15 counting cycles; without the macro timeout_o stays 0.

Source files
------------

// File: rtl/bsg_manycore_barrier_edge_responder.sv
// bsg_manycore_barrier_edge_responder
//
// Terminates the east-edge barrier links (local + ruche) of a compute-tile
// subarray and acts as a single aggregate barrier participant for all rows,
// optionally joined by a host participant through a valid/ready handshake.
// Once every participant has arrived, it waits sync_latency_p cycles and then
// releases the barrier by flipping its phase onto every outgoing link.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   barrier_link_i/o        per-row local barrier links (1-bit phase)
//   barrier_ruche_link_i/o  per-row ruche lanes, [row][lane] flattened
//   host_en_i               host takes part in the barrier
//   host_arrive_v_i/ready_o host arrival handshake
//   host_release_v_o        one-cycle release pulse to the host
//   barrier_count_o         completed barriers, wraps
//   error_o                 sticky protocol error (retraction / ruche mismatch)
//   timeout_o               sticky timeout flag
//
// Build option: define BSG_MANYCORE_BARRIER_RESP_TIMEOUT_EN to enable the
// partial-arrival timeout counter; otherwise timeout_o is tied to 0.

module bsg_manycore_barrier_edge_responder #(
    parameter int num_rows_p     = 4,
    parameter int ruche_factor_p = 3,
    parameter int sync_latency_p = 2,
    parameter int cnt_width_p    = 16
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [num_rows_p-1:0]                barrier_link_i,
    output logic [num_rows_p-1:0]                barrier_link_o,
    input  logic [num_rows_p*ruche_factor_p-1:0] barrier_ruche_link_i,
    output logic [num_rows_p*ruche_factor_p-1:0] barrier_ruche_link_o,
    input  logic                                 host_en_i,
    input  logic                                 host_arrive_v_i,
    output logic                                 host_arrive_ready_o,
    output logic                                 host_release_v_o,
    output logic [cnt_width_p-1:0]               barrier_count_o,
    output logic                                 error_o,
    output logic                                 timeout_o
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_DELAY   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam int NR     = num_rows_p * ruche_factor_p;
    localparam int DLY_W  = (sync_latency_p > 2) ? $clog2(sync_latency_p) : 1;
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'((sync_latency_p > 1) ? sync_latency_p - 1 : 0);

    logic [1:0]             r_state;
    logic                   r_phase;
    logic                   r_host_arrived;
    logic [num_rows_p-1:0]  r_arrived;
    logic [NR-1:0]          r_ruche_mis;
    logic [DLY_W-1:0]       r_dly;
    logic [cnt_width_p-1:0] r_count;
    logic                   r_error;

    logic [num_rows_p-1:0]  w_row_in;
    logic [NR-1:0]          w_ruche_mis;
    logic                   w_all_in;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_fire;
    logic                   w_retract;

    assign w_row_in = barrier_link_i ^ {num_rows_p{r_phase}};
    assign w_all_in = (&w_row_in) & (~host_en_i | r_host_arrived);

    always_comb begin
        w_ruche_mis = '0;
        for (int unsigned r = 0; r < num_rows_p; r++) begin
            for (int unsigned l = 0; l < ruche_factor_p; l++) begin
                w_ruche_mis[r*ruche_factor_p+l] = barrier_ruche_link_i[r*ruche_factor_p+l] ^ barrier_link_i[r];
            end
        end
    end

    assign w_ready  = ~reset_i & (r_state == ST_COLLECT) & host_en_i & ~r_host_arrived;
    assign w_accept = host_arrive_v_i & w_ready;

    // With zero sync latency the release happens on the arrival edge itself,
    // so the RELEASE state is bypassed and outputs flip one cycle after all_in.
    assign w_fire = (r_state == ST_RELEASE) |
                    ((sync_latency_p == 0) & (r_state == ST_COLLECT) & w_all_in);

    // A row that was seen arrived but now matches the phase again.
    assign w_retract = (|(r_arrived & ~w_row_in)) &
                       ((r_state == ST_COLLECT) | (r_state == ST_DELAY));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state        <= ST_COLLECT;
            r_phase        <= 1'b0;
            r_host_arrived <= 1'b0;
            r_arrived      <= '0;
            r_ruche_mis    <= '0;
            r_dly          <= '0;
            r_count        <= '0;
            r_error        <= 1'b0;
        end else begin
            r_ruche_mis <= w_ruche_mis;
            if ((|(r_ruche_mis & w_ruche_mis)) | w_retract)
                r_error <= 1'b1;

            if (w_fire) begin
                r_phase        <= ~r_phase;
                r_count        <= r_count + 1'b1;
                r_host_arrived <= 1'b0;
                r_arrived      <= '0;
                r_state        <= ST_COLLECT;
            end else begin
                case (r_state)
                    ST_COLLECT: begin
                        r_arrived <= w_row_in;
                        if (w_accept)
                            r_host_arrived <= 1'b1;
                        if (w_all_in) begin
                            if (sync_latency_p == 1) begin
                                r_state <= ST_RELEASE;
                            end else begin
                                r_state <= ST_DELAY;
                                r_dly   <= DLY_LOAD;
                            end
                        end
                    end
                    ST_DELAY: begin
                        r_arrived <= w_row_in;
                        // A retraction during the delay drops back to waiting.
                        if (!w_all_in)
                            r_state <= ST_COLLECT;
                        else if (r_dly <= DLY_W'(1))
                            r_state <= ST_RELEASE;
                        else
                            r_dly <= r_dly - 1'b1;
                    end
                    default: r_state <= ST_COLLECT;
                endcase
            end
        end
    end

`ifdef BSG_MANYCORE_BARRIER_RESP_TIMEOUT_EN
    localparam logic [cnt_width_p-1:0] TO_LAST = {{(cnt_width_p-1){1'b1}}, 1'b0};

    logic [cnt_width_p-1:0] r_to_cnt;
    logic                   r_timeout;
    logic                   w_partial;

    assign w_partial = (r_state == ST_COLLECT) & ((|w_row_in) | r_host_arrived) & ~w_all_in;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_fire) begin
            r_to_cnt <= '0;
        end else if (w_partial && (r_to_cnt != '1)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (r_to_cnt == TO_LAST)
                r_timeout <= 1'b1;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

    assign barrier_link_o       = {num_rows_p{r_phase}};
    assign barrier_ruche_link_o = {NR{r_phase}};
    assign host_arrive_ready_o  = w_ready;
    assign host_release_v_o     = ~reset_i & w_fire & host_en_i;
    assign barrier_count_o      = r_count;
    assign error_o              = r_error;

endmodule
